// File: rtl/fptoint.sv
// Multi-cycle IEEE-754 single to signed fixed-point converter.
// Alignment is a one-bit-per-cycle right shift; output is rounded half away from zero and saturated.
module fptoint #(
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned FRAC_BITS = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [31:0]          dataa,
  output logic [OUT_WIDTH-1:0] result,
  output logic                 done,
  output logic                 busy
);

  typedef enum logic [2:0] {StIdle, StUnpack, StShift, StRound, StDone} state_t;

  localparam logic [24:0] PosLim = 25'((64'd1 << (OUT_WIDTH - 1)) - 64'd1);
  localparam logic [24:0] NegLim = 25'(64'd1 << (OUT_WIDTH - 1));

  state_t      state;
  logic [31:0] op;
  logic [24:0] mag;
  logic [4:0]  cnt;
  logic        sat;

  logic        s;
  logic [7:0]  e;
  logic [22:0] frac;
  logic signed [9:0] sh;
  logic        force_zero;
  logic        force_sat;

  logic [24:0]          m_raw;
  logic [24:0]          lim;
  logic [24:0]          m_fin;
  logic [OUT_WIDTH-1:0] res_val;

  assign s    = op[31];
  assign e    = op[30:23];
  assign frac = op[22:0];
  assign sh   = 10'sd150 - $signed(10'(FRAC_BITS)) - $signed({2'b00, e});

  assign force_zero = ((e == 8'hff) && (frac != 23'd0)) || (e == 8'd0) || (sh > 10'sd25);
  assign force_sat  = (e == 8'hff) || (sh <= 10'sd0);

  always_comb begin
    m_raw   = {1'b0, mag[24:1]} + {24'd0, mag[0]};
    lim     = s ? NegLim : PosLim;
    m_fin   = (sat || (m_raw > lim)) ? lim : m_raw;
    res_val = s ? OUT_WIDTH'(-m_fin) : OUT_WIDTH'(m_fin);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= StIdle;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      op     <= '0;
      mag    <= '0;
      cnt    <= '0;
      sat    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            op    <= dataa;
            busy  <= 1'b1;
            state <= StUnpack;
          end
        end
        StUnpack: begin
          sat <= 1'b0;
          mag <= '0;
          cnt <= sh[4:0];
          if (force_zero) begin
            state <= StRound;
          end else if (force_sat) begin
            sat   <= 1'b1;
            state <= StRound;
          end else begin
            mag   <= {1'b1, frac, 1'b0};
            state <= StShift;
          end
        end
        StShift: begin
          // sh >= 1 here; the last shift moves straight on to rounding
          mag <= mag >> 1;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= StRound;
        end
        StRound: begin
          result <= res_val;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= StDone;
        end
        StDone: begin
          if (start) begin
            op    <= dataa;
            done  <= 1'b0;
            busy  <= 1'b1;
            state <= StUnpack;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fptoint.sv
// Scoreboard bench for fptoint (OUT_WIDTH=16, FRAC_BITS=15).
// Expected samples are queued at start and compared when done rises.
module tb_fptoint;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dataa;
  logic [15:0] result;
  logic        done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] sb[$];

  fptoint #(.OUT_WIDTH(16), .FRAC_BITS(15)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .dataa  (dataa),
    .result (result),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Latency counts the start-sampling cycle as cycle 1.
  task automatic run(input logic [31:0] a, input logic [15:0] exp, input int lat, input bit poke);
    int n;
    int nbusy;
    logic [15:0] want;
    sb.push_back(exp);
    @(negedge clk);
    start = 1'b1;
    dataa = a;
    @(negedge clk);
    start = 1'b0;
    dataa = $urandom;
    n     = 1;
    nbusy = 0;
    check("done_drop", {31'd0, done}, 32'd0);
    check("busy_rise", {31'd0, busy}, 32'd1);
    while (!done && n < 40) begin
      if (busy) nbusy++;
      if (poke && n == 3) begin
        start = 1'b1;
        dataa = 32'h3f800000;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (done && busy) check("done_busy_excl", 32'd1, 32'd0);
    end
    start = 1'b0;
    check("latency", n, lat);
    check("busy_cycles", nbusy, lat - 1);
    want = sb.pop_front();
    check($sformatf("result_%h", a), {16'd0, result}, {16'd0, want});
    check("busy_low", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [15:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[] = '{
    '{32'h3f000000, 16'h4000, 12},  // 0.5
    '{32'hbf400000, 16'ha000, 12},  // -0.75
    '{32'hbf800000, 16'h8000, 11},  // -1.0 exact negative limit
    '{32'h3fc00000, 16'h7fff, 11},  // 1.5 saturates
    '{32'hbfc00000, 16'h8000, 11},  // -1.5 saturates
    '{32'h7f800000, 16'h7fff, 3},   // +inf
    '{32'hff800000, 16'h8000, 3},   // -inf
    '{32'h47000000, 16'h7fff, 3},   // 32768.0, sh<=0
    '{32'h37800000, 16'h0001, 27},  // 2^-16 rounds up
    '{32'hb7800000, 16'hffff, 27},
    '{32'h37000000, 16'h0000, 28},  // 2^-17, sh=25
    '{32'h36800000, 16'h0000, 3},   // sh=26 forced zero
    '{32'h38400000, 16'h0002, 26},  // 1.5 LSB rounds to 2
    '{32'hb8400000, 16'hfffe, 26},
    '{32'h3ec00000, 16'h3000, 13},  // 0.375
    '{32'h3f000001, 16'h4000, 12},  // below half LSB truncates
    '{32'h7fc00000, 16'h0000, 3},   // NaN
    '{32'h00000001, 16'h0000, 3},   // denormal
    '{32'h80000000, 16'h0000, 3}    // -0
  };

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dataa = '0;
    repeat (3) @(negedge clk);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) run(vecs[i].a, vecs[i].exp, vecs[i].lat, 1'b0);

    // start pulse while busy must not disturb the conversion
    run(32'h3f000000, 16'h4000, 12, 1'b1);

    // reset in the middle of SHIFT aborts the run
    @(negedge clk);
    start = 1'b1;
    dataa = 32'h37800000;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_result", {16'd0, result}, 32'd0);

    run(32'hbf400000, 16'ha000, 12, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
